// File: rtl/multi_cycle_shifter.sv
// Iterative SLL/SRL/SRA/ROL shifter: moves up to STEP bit positions per clock
// under a start/busy/done handshake.
module multi_cycle_shifter #(
    parameter  int WIDTH = 32,
    parameter  int STEP  = 1,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [SHW-1:0]   shamt,
    input  logic [WIDTH-1:0] Data_in,
    output logic [WIDTH-1:0] Data_out,
    output logic             busy,
    output logic             done
);

    // state   | meaning
    // S_IDLE  | waiting for start
    // S_SHIFT | shifting, remaining amount in rem_q
    // S_DONE  | result valid for one cycle, start accepted here too
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0]     M_SLL   = 2'b00;
    localparam logic [1:0]     M_SRL   = 2'b01;
    localparam logic [1:0]     M_SRA   = 2'b10;
    localparam logic [SHW-1:0] STEP_W  = SHW'(STEP);
    localparam logic [SHW:0]   WIDTH_W = (SHW+1)'(WIDTH);

    state_t                  state_q;
    logic [WIDTH-1:0]        data_q;
    logic [SHW-1:0]          rem_q;
    logic [1:0]              mode_q;
    logic                    sign_q;

    logic [SHW-1:0]          k_d;
    logic [WIDTH-1:0]        shift_d;
    logic signed [WIDTH:0]   ext_d;

    always_comb begin
        k_d     = (rem_q < STEP_W) ? rem_q : STEP_W;
        // SRA fills from the sign captured at start, not the current MSB
        ext_d   = {sign_q, data_q};
        shift_d = data_q;
        case (mode_q)
            M_SLL:   shift_d = data_q << k_d;
            M_SRL:   shift_d = data_q >> k_d;
            M_SRA:   shift_d = WIDTH'(ext_d >>> k_d);
            default: shift_d = (data_q << k_d) | (data_q >> (WIDTH_W - {1'b0, k_d}));
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            rem_q   <= '0;
            mode_q  <= '0;
            sign_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        data_q  <= Data_in;
                        mode_q  <= mode;
                        rem_q   <= shamt;
                        sign_q  <= Data_in[WIDTH-1];
                        state_q <= (shamt != '0) ? S_SHIFT : S_DONE;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    data_q  <= shift_d;
                    rem_q   <= rem_q - k_d;
                    state_q <= (rem_q == k_d) ? S_DONE : S_SHIFT;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign Data_out = data_q;
    assign busy     = (state_q == S_SHIFT);
    assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_multi_cycle_shifter.sv
// Directed bench for multi_cycle_shifter: STEP=1 and STEP=4 instances run the
// same operations; back-to-back chaining is exercised on the STEP=1 instance.
module tb_multi_cycle_shifter;

    localparam logic [1:0] SLL = 2'b00, SRL = 2'b01, SRA = 2'b10, ROL = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start1;
    logic [1:0]  mode0, mode1;
    logic [4:0]  shamt0, shamt1;
    logic [31:0] din0, din1;
    logic [31:0] dout0, dout1;
    logic        busy0, busy1, done0, done1;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    multi_cycle_shifter #(.WIDTH(32), .STEP(1)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .mode(mode0), .shamt(shamt0),
        .Data_in(din0), .Data_out(dout0), .busy(busy0), .done(done0)
    );

    multi_cycle_shifter #(.WIDTH(32), .STEP(4)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .mode(mode1), .shamt(shamt1),
        .Data_in(din1), .Data_out(dout1), .busy(busy1), .done(done1)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [4:0]  shamt;
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];
    vec_t ops[10];

    function automatic logic [31:0] ref_shift(input logic [1:0] m, input logic [31:0] d,
                                              input logic [4:0] sh);
        logic [31:0] r;
        r = d;
        for (int i = 0; i < int'(sh); i++) begin
            case (m)
                SLL:     r = {r[30:0], 1'b0};
                SRL:     r = {1'b0, r[31:1]};
                SRA:     r = {r[31], r[31:1]};
                default: r = {r[30:0], r[31]};
            endcase
        end
        return r;
    endfunction

    function automatic int exp_busy(input int sh, input int s);
        return (sh + s - 1) / s;
    endfunction

    function automatic int exp_lat(input int sh, input int s);
        return (sh == 0) ? 1 : exp_busy(sh, s) + 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_both(input logic [1:0] m, input logic [4:0] sh, input logic [31:0] d,
                              input logic st);
        mode0 = m; shamt0 = sh; din0 = d; start0 = st;
        mode1 = m; shamt1 = sh; din1 = d; start1 = st;
    endtask

    // Issues one op to both DUTs; optionally pulses start with junk operands at cycle pulse_at.
    task automatic run_op(input logic [1:0] m, input logic [4:0] sh, input logic [31:0] d,
                          input int pulse_at,
                          output int lat0, output int lat1, output int b0, output int b1,
                          output logic [31:0] o0, output logic [31:0] o1);
        lat0 = 0; lat1 = 0; b0 = 0; b1 = 0; o0 = '0; o1 = '0;
        @(negedge clk);
        drive_both(m, sh, d, 1'b1);
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == 1 || n == pulse_at + 1) begin
                start0 = 1'b0; start1 = 1'b0;
            end
            if (n == pulse_at) drive_both(~m, 5'd5, 32'h5A5A5A5A, 1'b1);
            if (busy0) b0++;
            if (busy1) b1++;
            if (done0 && lat0 == 0) begin lat0 = n; o0 = dout0; end
            if (done1 && lat1 == 0) begin lat1 = n; o1 = dout1; end
            if (lat0 != 0 && lat1 != 0) break;
        end
    endtask

    task automatic check_op(input string tag, input logic [1:0] m, input logic [4:0] sh,
                            input logic [31:0] d, input logic [31:0] exp, input int pulse_at);
        int l0, l1, b0, b1;
        logic [31:0] o0, o1;
        run_op(m, sh, d, pulse_at, l0, l1, b0, b1, o0, o1);
        check({tag, " out s1"},  o0, exp);
        check({tag, " out s4"},  o1, exp);
        check({tag, " lat s1"},  32'(l0), 32'(exp_lat(int'(sh), 1)));
        check({tag, " lat s4"},  32'(l1), 32'(exp_lat(int'(sh), 4)));
        check({tag, " busy s1"}, 32'(b0), 32'(exp_busy(int'(sh), 1)));
        check({tag, " busy s4"}, 32'(b1), 32'(exp_busy(int'(sh), 4)));
    endtask

    initial begin
        int    idx, n;
        logic  seen;
        string tag;

        rst = 1'b1;
        drive_both(SLL, 5'd0, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        check("reset busy s1", 32'(busy0), 32'd0);
        check("reset done s1", 32'(done0), 32'd0);
        check("reset dout s1", dout0, 32'h0);
        check("reset busy s4", 32'(busy1), 32'd0);
        check("reset done s4", 32'(done1), 32'd0);
        check("reset dout s4", dout1, 32'h0);
        rst = 1'b0;

        vecs[0]  = '{SLL, 5'd2,  32'h03FFFFFF, 32'h0FFFFFFC};
        vecs[1]  = '{SRA, 5'd31, 32'h80000000, 32'hFFFFFFFF};
        vecs[2]  = '{SRL, 5'd31, 32'h80000000, 32'h00000001};
        vecs[3]  = '{ROL, 5'd4,  32'h80000001, 32'h00000018};
        vecs[4]  = '{SLL, 5'd0,  32'h12345678, 32'h12345678};
        vecs[5]  = '{SRL, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[6]  = '{SRA, 5'd0,  32'h80000000, 32'h80000000};
        vecs[7]  = '{ROL, 5'd0,  32'hCAFEF00D, 32'hCAFEF00D};
        vecs[8]  = '{SRA, 5'd4,  32'h7FFFFFFF, 32'h07FFFFFF};
        vecs[9]  = '{SRA, 5'd4,  32'hF0000000, 32'hFF000000};
        vecs[10] = '{ROL, 5'd8,  32'h12345678, 32'h34567812};
        vecs[11] = '{SLL, 5'd31, 32'h00000001, 32'h80000000};
        vecs[12] = '{SRL, 5'd5,  32'hF0000000, 32'h07800000};
        vecs[13] = '{ROL, 5'd31, 32'h80000000, 32'h40000000};
        vecs[14] = '{SRA, 5'd7,  32'h80000000, 32'hFF000000};
        vecs[15] = '{SLL, 5'd5,  32'hFFFFFFFF, 32'hFFFFFFE0};

        for (int i = 0; i < 16; i++) begin
            tag = $sformatf("vec%0d", i);
            check_op(tag, vecs[i].mode, vecs[i].shamt, vecs[i].din, vecs[i].exp, 0);
        end

        // start pulsed with different operands while busy must be ignored
        check_op("ignore-start", SRA, 5'd31, 32'h80000000, 32'hFFFFFFFF, 3);

        // reset in the middle of a shift
        @(negedge clk);
        drive_both(SLL, 5'd20, 32'hFFFF0000, 1'b1);
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
        repeat (2) @(negedge clk);
        check("pre-rst busy s1", 32'(busy0), 32'd1);
        check("pre-rst busy s4", 32'(busy1), 32'd1);
        rst = 1'b1;
        #1;
        check("rst busy s1", 32'(busy0), 32'd0);
        check("rst done s1", 32'(done0), 32'd0);
        check("rst dout s1", dout0, 32'h0);
        check("rst busy s4", 32'(busy1), 32'd0);
        check("rst done s4", 32'(done1), 32'd0);
        check("rst dout s4", dout1, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done0 || done1 || busy0 || busy1) seen = 1'b1;
        end
        check("no done after rst", 32'(seen), 32'd0);
        check_op("post-rst", SRL, 5'd4, 32'hF0000000, 32'h0F000000, 0);

        // back-to-back ops with start held high through DONE (STEP=1 instance)
        ops[0] = '{SLL, 5'd3, 32'h00000001, 32'h00000008};
        ops[1] = '{SRL, 5'd4, 32'hF0000000, 32'h0F000000};
        ops[2] = '{ROL, 5'd0, 32'hCAFEF00D, 32'hCAFEF00D};
        ops[3] = '{SRA, 5'd0, 32'h80000000, 32'h80000000};
        for (int i = 4; i < 10; i++) begin
            ops[i].mode  = 2'($urandom_range(0, 3));
            ops[i].shamt = 5'($urandom_range(0, 31));
            ops[i].din   = $urandom;
            ops[i].exp   = ref_shift(ops[i].mode, ops[i].din, ops[i].shamt);
        end
        start1 = 1'b0;
        @(negedge clk);
        mode0 = ops[0].mode; shamt0 = ops[0].shamt; din0 = ops[0].din; start0 = 1'b1;
        idx = 0;
        n = 0;
        for (int c = 0; c < 600 && idx < 10; c++) begin
            @(negedge clk);
            n++;
            if (done0) begin
                tag = $sformatf("b2b%0d", idx);
                check({tag, " lat"},  32'(n), 32'(exp_lat(int'(ops[idx].shamt), 1)));
                check({tag, " data"}, dout0, ops[idx].exp);
                idx++;
                n = 0;
                if (idx < 10) begin
                    mode0 = ops[idx].mode; shamt0 = ops[idx].shamt; din0 = ops[idx].din;
                end else begin
                    start0 = 1'b0;
                end
            end else if (n > exp_lat(int'(ops[idx].shamt), 1) + 2) begin
                break;
            end
        end
        check("b2b ops completed", 32'(idx), 32'd10);
        start0 = 1'b0;
        @(negedge clk);
        check("b2b done drops", 32'(done0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
